// File: rtl/wb_retire_queue_pkg.sv
// Shared types for the in-order writeback retire queue: common word type plus
// pipeline entry, result-source and memory-size definitions.
package common_pkg;
  localparam int XLEN = 64;
  typedef logic [XLEN-1:0] word_t;
endpackage

package pipes_pkg;
  import common_pkg::*;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_PC4 = 2'd1,
    SRC_MEM = 2'd2,
    SRC_CSR = 2'd3
  } wb_src_e;

  typedef enum logic [1:0] {
    MSIZE_B = 2'd0,
    MSIZE_H = 2'd1,
    MSIZE_W = 2'd2,
    MSIZE_D = 2'd3
  } msize_t;

  typedef struct packed {
    logic [4:0] dst;
    wb_src_e    sel;
    word_t      data;
    msize_t     msize;
    logic       munsigned;
    logic [2:0] maddr_lo;
    logic       is_mem;
    logic       ready;
  } wb_entry_t;
endpackage

// File: rtl/wb_retire_queue_load_extend.sv
// Combinational load-data extraction: align the response word by the address
// low bits, then truncate to the access size and sign/zero extend.
module load_extend
  import pipes_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      maddr_lo,
  input  logic [1:0]      msize,
  input  logic            munsigned,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;
  msize_t          eff_size;
  int              width;
  logic            sign;

  always_comb begin
    shifted  = rdata >> {maddr_lo, 3'b000};
    eff_size = msize_t'(msize);
    // A 32-bit datapath has no doubleword loads; fold D onto W.
    if (XLEN == 32 && eff_size == MSIZE_D) begin
      eff_size = MSIZE_W;
    end
    width = XLEN;
    sign  = shifted[XLEN-1];
    case (eff_size)
      MSIZE_B: begin width = 8;  sign = shifted[7];  end
      MSIZE_H: begin width = 16; sign = shifted[15]; end
      MSIZE_W: begin width = 32; sign = shifted[31]; end
      default: begin width = XLEN; sign = shifted[XLEN-1]; end
    endcase
    sign   = sign & ~munsigned;
    result = shifted;
    for (int i = 0; i < XLEN; i++) begin
      if (i >= width) begin
        result[i] = sign;
      end
    end
  end

endmodule

// File: rtl/wb_retire_queue.sv
// In-order writeback retire queue with in-order load response matching and
// flushed-load absorption. Define WB_PERF_EN to add retire/stall counters.
module wb_retire_queue
  import common_pkg::*;
  import pipes_pkg::*;
#(
  parameter int XLEN  = common_pkg::XLEN,
  parameter int DEPTH = 4,
  parameter int NSRC  = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_dst,
  input  logic [$clog2(NSRC)-1:0] in_sel,
  input  logic [XLEN-1:0]         in_alu,
  input  logic [XLEN-1:0]         in_pcplus4,
  input  logic [XLEN-1:0]         in_csr,
  input  logic [1:0]              in_msize,
  input  logic                    in_munsigned,
  input  logic [2:0]              in_maddr_lo,
  input  logic                    mem_rvalid,
  input  logic [XLEN-1:0]         mem_rdata,
  input  logic                    flush,
  output logic                    wb_valid,
  output logic                    wb_wen,
  output logic [4:0]              wb_dst,
  output logic [XLEN-1:0]         wb_data
`ifdef WB_PERF_EN
  ,
  output logic [63:0]             perf_retired,
  output logic [63:0]             perf_load_stall
`endif
);

  localparam int PW       = $clog2(DEPTH);
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int DW       = $clog2(DEPTH * 2) + 1;
  localparam int DROP_MAX = (1 << DW) - 1;

  wb_entry_t       entries_q [DEPTH];
  wb_entry_t       entries_d [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   drop_cnt_q, drop_cnt_d;

  wb_entry_t       head_e, new_e;
  wb_src_e         src;
  logic            enq, pop, rsp_drop, rsp_fill;
  logic            fill_old;
  logic [PW-1:0]   fill_idx, idx;
  logic [CW-1:0]   pending;
  int              drop_sum;
  logic [XLEN-1:0] ext_rdata_in, ext_result;
  logic [2:0]      ext_maddr;
  logic [1:0]      ext_msize;
  logic            ext_unsigned;

  assign head_e   = entries_q[head_q];
  assign in_ready = count_q < CW'(DEPTH);
  assign wb_valid = (count_q != '0) && head_e.ready && !flush;
  assign wb_wen   = wb_valid && (head_e.dst != 5'd0);
  assign wb_dst   = wb_valid ? head_e.dst : 5'd0;
  assign wb_data  = wb_valid ? XLEN'(head_e.data) : '0;

  always_comb begin
    src = SRC_ALU;
    if (int'(in_sel) < NSRC) begin
      case (int'(in_sel))
        1:       src = SRC_PC4;
        2:       src = SRC_MEM;
        3:       src = SRC_CSR;
        default: src = SRC_ALU;
      endcase
    end
  end

  // Oldest unfilled load within the live window, plus how many are outstanding.
  always_comb begin
    fill_old = 1'b0;
    fill_idx = head_q;
    pending  = '0;
    idx      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q && entries_q[idx].is_mem && !entries_q[idx].ready) begin
        pending = pending + CW'(1);
        if (!fill_old) begin
          fill_old = 1'b1;
          fill_idx = idx;
        end
      end
    end
  end

  always_comb begin
    if (fill_old) begin
      ext_maddr    = entries_q[fill_idx].maddr_lo;
      ext_msize    = entries_q[fill_idx].msize;
      ext_unsigned = entries_q[fill_idx].munsigned;
    end else begin
      ext_maddr    = in_maddr_lo;
      ext_msize    = in_msize;
      ext_unsigned = in_munsigned;
    end
    ext_rdata_in = mem_rdata;
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata     (ext_rdata_in),
    .maddr_lo  (ext_maddr),
    .msize     (ext_msize),
    .munsigned (ext_unsigned),
    .result    (ext_result)
  );

  always_comb begin
    new_e.dst       = in_dst;
    new_e.sel       = src;
    new_e.msize     = msize_t'(in_msize);
    new_e.munsigned = in_munsigned;
    new_e.maddr_lo  = in_maddr_lo;
    new_e.is_mem    = (src == SRC_MEM);
    new_e.ready     = (src != SRC_MEM);
    case (src)
      SRC_PC4: new_e.data = word_t'(in_pcplus4);
      SRC_CSR: new_e.data = word_t'(in_csr);
      SRC_MEM: new_e.data = '0;
      default: new_e.data = word_t'(in_alu);
    endcase
  end

  // Queue state update; flush wins over enqueue, retire and fill.
  always_comb begin
    entries_d  = entries_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    drop_sum   = 0;
    enq        = in_valid && in_ready && !flush;
    pop        = wb_valid;
    rsp_drop   = mem_rvalid && (drop_cnt_q != '0);
    rsp_fill   = mem_rvalid && !rsp_drop && (fill_old || (enq && new_e.is_mem));

    if (flush) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      drop_sum = int'(drop_cnt_q) + int'(pending) - int'(rsp_drop)
               - int'(mem_rvalid && !rsp_drop && fill_old);
      if (drop_sum > DROP_MAX) begin
        drop_sum = DROP_MAX;
      end
      drop_cnt_d = DW'(drop_sum);
    end else begin
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - DW'(1);
      end
      if (rsp_fill && fill_old) begin
        entries_d[fill_idx].data  = word_t'(ext_result);
        entries_d[fill_idx].ready = 1'b1;
      end
      if (enq) begin
        entries_d[tail_q] = new_e;
        if (rsp_fill && !fill_old) begin
          entries_d[tail_q].data  = word_t'(ext_result);
          entries_d[tail_q].ready = 1'b1;
        end
        tail_d = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(enq) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      entries_q  <= entries_d;
    end
  end

`ifdef WB_PERF_EN
  logic [63:0] perf_retired_q, perf_retired_d;
  logic [63:0] perf_load_stall_q, perf_load_stall_d;

  always_comb begin
    perf_retired_d    = perf_retired_q + 64'(wb_valid);
    perf_load_stall_d = perf_load_stall_q
                      + 64'((count_q != '0) && head_e.is_mem && !head_e.ready);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_retired_q    <= '0;
      perf_load_stall_q <= '0;
    end else begin
      perf_retired_q    <= perf_retired_d;
      perf_load_stall_q <= perf_load_stall_d;
    end
  end

  assign perf_retired    = perf_retired_q;
  assign perf_load_stall = perf_load_stall_q;
`endif

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed self-checking bench for wb_retire_queue: ALU/PC4/CSR retire, load
// extraction, full queue, flush absorption and same-cycle response fill.
module tb_wb_retire_queue;

   localparam logic [1:0] SEL_ALU = 2'd0;
   localparam logic [1:0] SEL_PC4 = 2'd1;
   localparam logic [1:0] SEL_MEM = 2'd2;
   localparam logic [1:0] SEL_CSR = 2'd3;

   logic        clk;
   logic        resetn;
   logic        inValid;
   logic        inReady;
   logic [4:0]  inDst;
   logic [1:0]  inSel;
   logic [63:0] inAlu;
   logic [63:0] inPcPlus4;
   logic [63:0] inCsr;
   logic [1:0]  inMsize;
   logic        inMunsigned;
   logic [2:0]  inMaddrLo;
   logic        memRvalid;
   logic [63:0] memRdata;
   logic        flush;
   logic        wbValid;
   logic        wbWen;
   logic [4:0]  wbDst;
   logic [63:0] wbData;
`ifdef WB_PERF_EN
   logic [63:0] perfRetired;
   logic [63:0] perfLoadStall;
`endif

   int checkCount = 0;
   int errorCount = 0;

   wb_retire_queue dut (
      .clk          (clk),
      .resetn       (resetn),
      .in_valid     (inValid),
      .in_ready     (inReady),
      .in_dst       (inDst),
      .in_sel       (inSel),
      .in_alu       (inAlu),
      .in_pcplus4   (inPcPlus4),
      .in_csr       (inCsr),
      .in_msize     (inMsize),
      .in_munsigned (inMunsigned),
      .in_maddr_lo  (inMaddrLo),
      .mem_rvalid   (memRvalid),
      .mem_rdata    (memRdata),
      .flush        (flush),
      .wb_valid     (wbValid),
      .wb_wen       (wbWen),
      .wb_dst       (wbDst),
      .wb_data      (wbData)
`ifdef WB_PERF_EN
      ,
      .perf_retired    (perfRetired),
      .perf_load_stall (perfLoadStall)
`endif
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Checks the writeback port; dst/data/wen only matter when a retire is expected.
   task automatic checkWb(input string tag, input logic expValid, input logic [4:0] expDst,
                          input logic [63:0] expData);
      checkOutput({tag, ".valid"}, 64'(wbValid), 64'(expValid));
      if (expValid) begin
         checkOutput({tag, ".dst"}, 64'(wbDst), 64'(expDst));
         checkOutput({tag, ".data"}, wbData, expData);
         checkOutput({tag, ".wen"}, 64'(wbWen), 64'(expDst != 5'd0));
      end
   endtask

   // Drives one cycle worth of inputs; alu/pc4/csr get distinct values so the source mux is visible.
   task automatic applyStimulus(input logic v, input logic [4:0] dst, input logic [1:0] sel,
                                input logic [63:0] val, input logic [1:0] msize, input logic uns,
                                input logic [2:0] maddr, input logic rv, input logic [63:0] rdata,
                                input logic fl);
      inValid     = v;
      inDst       = dst;
      inSel       = sel;
      inAlu       = val;
      inPcPlus4   = val + 64'd1;
      inCsr       = val + 64'd2;
      inMsize     = msize;
      inMunsigned = uns;
      inMaddrLo   = maddr;
      memRvalid   = rv;
      memRdata    = rdata;
      flush       = fl;
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, SEL_ALU, 64'd0, 2'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed scenario sequence with hand-computed expectations.
   initial begin
      resetn = 1'b0;
      idle();
      tick();
      tick();
      checkOutput("reset.in_ready", 64'(inReady), 64'd1);
      checkWb("reset", 1'b0, 5'd0, 64'd0);
      checkOutput("reset.wb_wen", 64'(wbWen), 64'd0);
      checkOutput("reset.wb_dst", 64'(wbDst), 64'd0);
      checkOutput("reset.wb_data", wbData, 64'd0);
      resetn = 1'b1;

      // ALU, then PC+4, then CSR back to back.
      applyStimulus(1'b1, 5'd5, SEL_ALU, 64'h1234, 2'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b0);
      checkOutput("alu.in_ready", 64'(inReady), 64'd1);
      checkWb("alu.pre", 1'b0, 5'd0, 64'd0);
      tick();
      applyStimulus(1'b1, 5'd6, SEL_PC4, 64'h4000, 2'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b0);
      checkWb("alu", 1'b1, 5'd5, 64'h1234);
      checkOutput("alu.in_ready2", 64'(inReady), 64'd1);
      tick();
      applyStimulus(1'b1, 5'd2, SEL_CSR, 64'h500, 2'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b0);
      checkWb("pc4", 1'b1, 5'd6, 64'h4001);
      tick();
      idle();
      checkWb("csr", 1'b1, 5'd2, 64'h502);
      tick();
      checkWb("alu.drain", 1'b0, 5'd0, 64'd0);

      // Signed byte load at offset 3, then an ALU op behind it.
      applyStimulus(1'b1, 5'd7, SEL_MEM, 64'd0, 2'd0, 1'b0, 3'd3, 1'b0, 64'd0, 1'b0);
      tick();
      applyStimulus(1'b1, 5'd8, SEL_ALU, 64'hAA, 2'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b0);
      checkWb("lb.wait1", 1'b0, 5'd0, 64'd0);
      tick();
      idle();
      checkWb("lb.wait2", 1'b0, 5'd0, 64'd0);
      tick();
      applyStimulus(1'b0, 5'd0, SEL_ALU, 64'd0, 2'd0, 1'b0, 3'd0, 1'b1, 64'h00000000_80FF0000, 1'b0);
      checkWb("lb.rsp", 1'b0, 5'd0, 64'd0);
      tick();
      idle();
      checkWb("lb", 1'b1, 5'd7, 64'hFFFFFFFF_FFFFFF80);
      tick();
      checkWb("lb.alu", 1'b1, 5'd8, 64'hAA);
      tick();
      checkWb("lb.drain", 1'b0, 5'd0, 64'd0);

      // Fill the queue with four doubleword loads.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'(10 + i), SEL_MEM, 64'd0, 2'd3, 1'b1, 3'd0, 1'b0, 64'd0, 1'b0);
         checkOutput($sformatf("full.ready%0d", i), 64'(inReady), 64'd1);
         tick();
      end
      applyStimulus(1'b1, 5'd30, SEL_ALU, 64'h30, 2'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b0);
      checkOutput("full.in_ready", 64'(inReady), 64'd0);
      tick();
      applyStimulus(1'b0, 5'd0, SEL_ALU, 64'd0, 2'd0, 1'b0, 3'd0, 1'b1, 64'h1111, 1'b0);
      checkOutput("full.in_ready_rsp", 64'(inReady), 64'd0);
      tick();
      applyStimulus(1'b0, 5'd0, SEL_ALU, 64'd0, 2'd0, 1'b0, 3'd0, 1'b1, 64'h2222, 1'b0);
      checkWb("full.r0", 1'b1, 5'd10, 64'h1111);
      checkOutput("full.in_ready_pop", 64'(inReady), 64'd0);
      tick();
      applyStimulus(1'b0, 5'd0, SEL_ALU, 64'd0, 2'd0, 1'b0, 3'd0, 1'b1, 64'h3333, 1'b0);
      checkWb("full.r1", 1'b1, 5'd11, 64'h2222);
      checkOutput("full.in_ready_after", 64'(inReady), 64'd1);
      tick();
      applyStimulus(1'b0, 5'd0, SEL_ALU, 64'd0, 2'd0, 1'b0, 3'd0, 1'b1, 64'h4444, 1'b0);
      checkWb("full.r2", 1'b1, 5'd12, 64'h3333);
      tick();
      idle();
      checkWb("full.r3", 1'b1, 5'd13, 64'h4444);
      tick();
      checkWb("full.drain", 1'b0, 5'd0, 64'd0);

      // Flush masks a ready head and discards it.
      applyStimulus(1'b1, 5'd9, SEL_ALU, 64'h99, 2'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b0);
      tick();
      applyStimulus(1'b0, 5'd0, SEL_ALU, 64'd0, 2'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b1);
      checkWb("flush.mask", 1'b0, 5'd0, 64'd0);
      tick();
      idle();
      checkWb("flush.gone", 1'b0, 5'd0, 64'd0);

      // Two loads flushed; their responses must be absorbed.
      applyStimulus(1'b1, 5'd14, SEL_MEM, 64'd0, 2'd3, 1'b1, 3'd0, 1'b0, 64'd0, 1'b0);
      tick();
      applyStimulus(1'b1, 5'd15, SEL_MEM, 64'd0, 2'd3, 1'b1, 3'd0, 1'b0, 64'd0, 1'b0);
      tick();
      applyStimulus(1'b1, 5'd20, SEL_ALU, 64'hD0, 2'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b1);
      checkWb("drop.flush", 1'b0, 5'd0, 64'd0);
      tick();
      applyStimulus(1'b1, 5'd21, SEL_ALU, 64'h77, 2'd0, 1'b0, 3'd0, 1'b1, 64'h5555, 1'b0);
      checkWb("drop.rsp1", 1'b0, 5'd0, 64'd0);
      tick();
      applyStimulus(1'b0, 5'd0, SEL_ALU, 64'd0, 2'd0, 1'b0, 3'd0, 1'b1, 64'h6666, 1'b0);
      checkWb("drop.alu", 1'b1, 5'd21, 64'h77);
      tick();
      applyStimulus(1'b1, 5'd22, SEL_MEM, 64'd0, 2'd3, 1'b1, 3'd0, 1'b1, 64'h0123, 1'b0);
      checkWb("drop.done", 1'b0, 5'd0, 64'd0);
      tick();
      idle();
      checkWb("drop.newload", 1'b1, 5'd22, 64'h0123);
      tick();
      checkWb("drop.drain", 1'b0, 5'd0, 64'd0);

      // LHU to x0 at offset 6: retires without a register write.
      applyStimulus(1'b1, 5'd0, SEL_MEM, 64'd0, 2'd1, 1'b1, 3'd6, 1'b0, 64'd0, 1'b0);
      tick();
      applyStimulus(1'b0, 5'd0, SEL_ALU, 64'd0, 2'd0, 1'b0, 3'd0, 1'b1, 64'hBEEF0000_00000000, 1'b0);
      checkWb("lhu.rsp", 1'b0, 5'd0, 64'd0);
      tick();
      idle();
      checkWb("lhu", 1'b1, 5'd0, 64'h00000000_0000BEEF);
      checkOutput("lhu.wen", 64'(wbWen), 64'd0);
      tick();

      // Signed word load with the response in its own enqueue cycle.
      applyStimulus(1'b1, 5'd3, SEL_MEM, 64'd0, 2'd2, 1'b0, 3'd4, 1'b1, 64'h80000001_00000000, 1'b0);
      checkWb("same.enq", 1'b0, 5'd0, 64'd0);
      tick();
      idle();
      checkWb("same", 1'b1, 5'd3, 64'hFFFFFFFF_80000001);
      tick();
      checkWb("same.drain", 1'b0, 5'd0, 64'd0);
      checkOutput("end.in_ready", 64'(inReady), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
